vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Free-running horizontal/vertical counter and decoder for the VGA path; sits directly upstream of the sync/visibility register stage.
- Produces the one-cycle strobes and level decodes that stage consumes: begin/end of h/v sync pulse, end of line, end of visible regions, vertical zero/end, end of active frame.
- Also exports the pixel coordinates (hcount, vcount) for the pixel-fetch logic.
- Default timing is 640x480@60 (800 x 525 total).

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- CW, 10, counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel clock enable; counters advance only when 1
- hcount  out  CW  horizontal position, 0..H_TOTAL-1
- vcount  out  CW  vertical position, 0..V_TOTAL-1
- hBeginPulse  out  1  strobe: h sync begins next cycle
- hEndPulse  out  1  strobe: h sync ends next cycle
- vBeginPulse  out  1  strobe: v sync begins next cycle
- vEndPulse  out  1  strobe: v sync ends next cycle
- hCountEnd  out  1  strobe: last pixel of line
- hVisEnd  out  1  strobe: last visible pixel of line
- vCountZero  out  1  level: vcount == 0
- vVisEnd  out  1  level: vcount == V_VISIBLE
- vCountEnd  out  1  level: vcount == V_TOTAL-1
- vEndActive  out  1  strobe: last visible pixel of last visible line
- frameCount  out  16  frames completed (TIMING_FRAME_CNT_EN only)

Behaviour:
- Derived values:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK
  - HS_START = H_VISIBLE + H_FRONT - 1
  - HS_END = HS_START + H_SYNC
  - V_TOTAL and VS_START/VS_END are formed the same way from the V_ parameters.
- Reset: hcount = 0, vcount = 0, frameCount = 0.
  - All strobes are 0 during reset, because strobes are gated by the registered counters and ce only.
  - First frame after reset: the downstream vVis stays low until vCountZero coincides with hCountEnd. This is accepted behaviour.
- Horizontal counter:
  - On ce: if hcount == H_TOTAL-1, hcount <= 0; else hcount <= hcount + 1.
  - ce = 0 holds all state.
- Vertical counter:
  - Advances mid-line, on ce & (hcount == HS_START), not at end of line.
  - Wraps from V_TOTAL-1 to 0.
  - Consequence: vcount is already 0 at hCountEnd of the final line, so the downstream stage opens vertical visibility on vCountZero & hCountEnd.
- All strobes are combinational decodes of the registered counters ANDed with ce, so each is high for exactly one ce-qualified cycle:
  - hVisEnd = ce & hcount == H_VISIBLE-1
  - hBeginPulse = ce & hcount == HS_START
  - hEndPulse = ce & hcount == HS_END
  - hCountEnd = ce & hcount == H_TOTAL-1
  - vBeginPulse = ce & hcount == HS_START & vcount == VS_START (coincides with the increment to VS_START+1)
  - vEndPulse = ce & hcount == HS_START & vcount == VS_END
  - vEndActive = ce & hcount == H_VISIBLE-1 & vcount == V_VISIBLE-1
- Level decodes (vCountZero, vVisEnd, vCountEnd) are not ce-gated; the consumer qualifies them with hCountEnd.
- Simultaneous events:
  - hBeginPulse and vBeginPulse coincide by design.
  - hCountEnd and vCountEnd/vCountZero both true at the frame boundary is legal; no priority is needed.
- Reset mid-frame: counters return to 0 on the next clk regardless of ce; no partial strobe is emitted in the reset cycle.
- Zero latency: decodes reflect the current counter value; no pipeline.

Optional Feature:
- TIMING_FRAME_CNT_EN defined:
  - 16-bit frameCount increments on ce & hCountEnd & vCountEnd.
  - Wraps 0xFFFF -> 0; reset to 0.
- Undefined: the frameCount port is absent and there is no counter logic.

Test Plan:
- Reset, ce = 1 for 800 cycles -> hVisEnd at hcount 639, hBeginPulse at 655, hEndPulse at 751, hCountEnd at 799, each exactly 1 cycle; hcount = 0 on cycle 800.
- ce toggling 1/0 -> counters advance only on ce = 1; each strobe high for one ce cycle only; a line spans 1600 clk.
- Run one full frame (420000 ce cycles) -> vcount changes at hcount 655; vBeginPulse when vcount 489 -> 490; vEndPulse when vcount 491 -> 492; vcount 524 -> 0 at hcount 655 of line 524.
- At hCountEnd of line 524 -> vCountZero = 1 and vCountEnd = 0; at hCountEnd of line 479 (vcount already 480) -> vVisEnd = 1; vEndActive once per frame at hcount 639, vcount 479.
- Assert rst at hcount 300, vcount 200 for one cycle -> next cycle hcount = 0, vcount = 0; no strobe in the reset cycle.
- With TIMING_FRAME_CNT_EN: 3 full frames -> frameCount = 3; preload 0xFFFF via force -> wraps to 0 at the next frame end.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA h/v counters with one-cycle event strobes.
// Optional TIMING_FRAME_CNT_EN adds a 16-bit completed-frame counter (frameCount).
//
// Ports:
//   clk, rst (sync, active high), ce (pixel clock enable)
//   hcount/vcount       : current pixel coordinates
//   hBeginPulse/hEndPulse, vBeginPulse/vEndPulse : sync edge strobes (next cycle)
//   hCountEnd, hVisEnd, vEndActive               : ce-qualified strobes
//   vCountZero, vVisEnd, vCountEnd               : ungated level decodes
//   frameCount                                   : frames done (feature only)
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hBeginPulse,
    output logic          hEndPulse,
    output logic          vBeginPulse,
    output logic          vEndPulse,
    output logic          hCountEnd,
    output logic          hVisEnd,
    output logic          vCountZero,
    output logic          vVisEnd,
    output logic          vCountEnd,
    output logic          vEndActive
`ifdef TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frameCount
`endif
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT - 1;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int VS_START = V_VISIBLE + V_FRONT - 1;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_VLAST  = CW'(H_VISIBLE - 1);
    localparam logic [CW-1:0] H_SSTART = CW'(HS_START);
    localparam logic [CW-1:0] H_SEND   = CW'(HS_END);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_VLAST  = CW'(V_VISIBLE - 1);
    localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] V_SSTART = CW'(VS_START);
    localparam logic [CW-1:0] V_SEND   = CW'(VS_END);

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          h_at_last;
    logic          h_at_sstart;

    always_comb begin
        h_at_last   = (hcount_q == H_LAST);
        h_at_sstart = (hcount_q == H_SSTART);

        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (ce) begin
            hcount_d = h_at_last ? '0 : hcount_q + CW'(1);
            // Vertical steps mid-line at sync start, so the new line
            // number is already valid by the end of the current line.
            if (h_at_sstart) begin
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount = hcount_q;
    assign vcount = vcount_q;

    assign hVisEnd     = ce & (hcount_q == H_VLAST);
    assign hBeginPulse = ce & h_at_sstart;
    assign hEndPulse   = ce & (hcount_q == H_SEND);
    assign hCountEnd   = ce & h_at_last;
    assign vBeginPulse = ce & h_at_sstart & (vcount_q == V_SSTART);
    assign vEndPulse   = ce & h_at_sstart & (vcount_q == V_SEND);
    assign vEndActive  = ce & (hcount_q == H_VLAST) & (vcount_q == V_VLAST);

    assign vCountZero = (vcount_q == '0);
    assign vVisEnd    = (vcount_q == V_VIS);
    assign vCountEnd  = (vcount_q == V_LAST);

`ifdef TIMING_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (ce & h_at_last & vCountEnd) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frameCount = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen, default 640x480
// timing for the horizontal path plus a tiny-timing instance for frames.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default-timing instance
    logic       rst, ce;
    logic [9:0] hcount, vcount;
    logic       h_beg, h_end, v_beg, v_end, h_ce, h_ve;
    logic       v_zero, v_vis, v_cend, v_ea;
`ifdef TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    vga_timing_gen dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .hcount      (hcount),
        .vcount      (vcount),
        .hBeginPulse (h_beg),
        .hEndPulse   (h_end),
        .vBeginPulse (v_beg),
        .vEndPulse   (v_end),
        .hCountEnd   (h_ce),
        .hVisEnd     (h_ve),
        .vCountZero  (v_zero),
        .vVisEnd     (v_vis),
        .vCountEnd   (v_cend),
        .vEndActive  (v_ea)
`ifdef TIMING_FRAME_CNT_EN
        ,
        .frameCount  (frame_cnt)
`endif
    );

    // Tiny instance: H 8+2+3+2=15 (HS_START 9, HS_END 12),
    // V 6+2+2+3=13 (VS_START 7, VS_END 9), 195 clocks per frame.
    logic       s_rst, s_ce;
    logic [3:0] s_hcount, s_vcount;
    logic       s_hbeg, s_hend, s_vbeg, s_vend, s_hce, s_hve;
    logic       s_vzero, s_vvis, s_vcend, s_vea;
`ifdef TIMING_FRAME_CNT_EN
    logic [15:0] s_frame_cnt;
`endif

    vga_timing_gen #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_VISIBLE (6),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (3),
        .CW        (4)
    ) sdut (
        .clk         (clk),
        .rst         (s_rst),
        .ce          (s_ce),
        .hcount      (s_hcount),
        .vcount      (s_vcount),
        .hBeginPulse (s_hbeg),
        .hEndPulse   (s_hend),
        .vBeginPulse (s_vbeg),
        .vEndPulse   (s_vend),
        .hCountEnd   (s_hce),
        .hVisEnd     (s_hve),
        .vCountZero  (s_vzero),
        .vVisEnd     (s_vvis),
        .vCountEnd   (s_vcend),
        .vEndActive  (s_vea)
`ifdef TIMING_FRAME_CNT_EN
        ,
        .frameCount  (s_frame_cnt)
`endif
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_ve, n_hb, n_he, n_ce, i_ve, i_hb, i_he, i_ce;
        int bad_h, bad_v, gated, found;
        int n_vb, n_vd, n_ea, i_vb, i_vd, i_ea, n_fe, i_fe;
        int v189, v190, z194, e194, c194, vv89, c89;

        rst   = 1'b1;
        ce    = 1'b1;
        s_rst = 1'b1;
        s_ce  = 1'b1;
        tick();
        tick();
        check_eq("rst_hcount", hcount, 0);
        check_eq("rst_vcount", vcount, 0);
        check_eq("rst_strobes",
                 {h_beg, h_end, v_beg, v_end, h_ce, h_ve, v_ea}, 0);
        check_eq("rst_vzero", v_zero, 1);
`ifdef TIMING_FRAME_CNT_EN
        check_eq("rst_frame", frame_cnt, 0);
`endif

        // One line with ce held high
        rst = 1'b0;
        #1;
        n_ve = 0; n_hb = 0; n_he = 0; n_ce = 0;
        i_ve = -1; i_hb = -1; i_he = -1; i_ce = -1;
        bad_h = 0; bad_v = 0;
        for (int i = 0; i < 800; i++) begin
            if (hcount != 10'(i)) bad_h++;
            if (vcount != ((i >= 656) ? 10'd1 : 10'd0)) bad_v++;
            if (h_ve) begin n_ve++; i_ve = i; end
            if (h_beg) begin n_hb++; i_hb = i; end
            if (h_end) begin n_he++; i_he = i; end
            if (h_ce) begin n_ce++; i_ce = i; end
            tick();
        end
        check_eq("line_hcount_seq", bad_h, 0);
        check_eq("line_vstep_at_655", bad_v, 0);
        check_eq("hvisend_cnt", n_ve, 1);
        check_eq("hvisend_at", i_ve, 639);
        check_eq("hbegin_cnt", n_hb, 1);
        check_eq("hbegin_at", i_hb, 655);
        check_eq("hend_cnt", n_he, 1);
        check_eq("hend_at", i_he, 751);
        check_eq("hcountend_cnt", n_ce, 1);
        check_eq("hcountend_at", i_ce, 799);
        check_eq("line_wrap_h", hcount, 0);
        check_eq("line_wrap_v", vcount, 1);

        // ce toggling: one line spans 1600 clocks
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_ve = 0; n_hb = 0; n_he = 0; n_ce = 0;
        i_ce = -1; bad_h = 0; gated = 0;
        for (int i = 0; i < 1600; i++) begin
            ce = (i % 2 == 0);
            #1;
            if (int'(hcount) != ((i + 1) / 2) % 800) bad_h++;
            if (!ce && (h_beg | h_end | h_ce | h_ve | v_beg | v_end | v_ea))
                gated++;
            if (h_ve) n_ve++;
            if (h_beg) n_hb++;
            if (h_end) n_he++;
            if (h_ce) begin n_ce++; i_ce = i; end
            tick();
        end
        check_eq("ce_hold_seq", bad_h, 0);
        check_eq("ce_gated_strobes", gated, 0);
        check_eq("ce_hvisend_cnt", n_ve, 1);
        check_eq("ce_hbegin_cnt", n_hb, 1);
        check_eq("ce_hend_cnt", n_he, 1);
        check_eq("ce_hcountend_at", i_ce, 1598);
        check_eq("ce_line_h", hcount, 0);
        check_eq("ce_line_v", vcount, 1);
        ce = 1'b1;

        // Tiny instance: frame-level events
        s_rst = 1'b0;
        #1;
        n_vb = 0; n_vd = 0; n_ea = 0; n_fe = 0;
        i_vb = -1; i_vd = -1; i_ea = -1; i_fe = -1;
        v189 = -1; v190 = -1; z194 = -1; e194 = -1; c194 = -1;
        vv89 = -1; c89 = -1; gated = 0;
        for (int i = 0; i < 585; i++) begin
            if (i < 195) begin
                if (s_vbeg) begin
                    n_vb++; i_vb = i;
                    if (!s_hbeg) gated++;
                end
                if (s_vend) begin n_vd++; i_vd = i; end
                if (s_vea) begin n_ea++; i_ea = i; end
                if (s_hce && s_vcend) begin n_fe++; i_fe = i; end
                if (i == 189) v189 = int'(s_vcount);
                if (i == 190) v190 = int'(s_vcount);
                if (i == 194) begin
                    z194 = s_vzero; e194 = s_vcend; c194 = s_hce;
                end
                if (i == 89) begin vv89 = s_vvis; c89 = s_hce; end
            end
            tick();
        end
        check_eq("vbegin_cnt", n_vb, 1);
        check_eq("vbegin_at", i_vb, 114);
        check_eq("vbegin_with_hbegin", gated, 0);
        check_eq("vend_cnt", n_vd, 1);
        check_eq("vend_at", i_vd, 144);
        check_eq("vendactive_cnt", n_ea, 1);
        check_eq("vendactive_at", i_ea, 82);
        check_eq("vlast_before_wrap", v189, 12);
        check_eq("vwrap_mid_line", v190, 0);
        check_eq("frame_end_vzero", z194, 1);
        check_eq("frame_end_vcend", e194, 0);
        check_eq("frame_end_hce", c194, 1);
        check_eq("visend_level", vv89, 1);
        check_eq("visend_hce", c89, 1);
        check_eq("vcend_hce_at", i_fe, 179);
        check_eq("vcend_hce_cnt", n_fe, 1);
`ifdef TIMING_FRAME_CNT_EN
        check_eq("frame_cnt_3", s_frame_cnt, 3);
        force sdut.frame_count_q = 16'hFFFF;
        #1;
        release sdut.frame_count_q;
        for (int i = 0; i < 195; i++) tick();
        check_eq("frame_cnt_wrap", s_frame_cnt, 0);
`endif

        // Reset mid-frame at hcount 5, vcount 4 (no decode active there)
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            if (s_hcount == 4'd5 && s_vcount == 4'd4) found = 1;
            else tick();
        end
        check_eq("midrst_reached", found, 1);
        s_rst = 1'b1;
        #1;
        check_eq("midrst_no_strobe",
                 {s_hbeg, s_hend, s_vbeg, s_vend, s_hce, s_hve, s_vea}, 0);
        tick();
        s_rst = 1'b0;
        check_eq("midrst_h", s_hcount, 0);
        check_eq("midrst_v", s_vcount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
